// File: rtl/clock_display_pkg.sv
// Shared constants for the six-digit HH.MM.SS multiplexed display:
// segment codes {g,f,e,d,c,b,a}, digit slot indices and field maxima.
package clock_display_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   localparam logic [2:0] DIG_HR_T  = 3'd0;
   localparam logic [2:0] DIG_HR_U  = 3'd1;
   localparam logic [2:0] DIG_MIN_T = 3'd2;
   localparam logic [2:0] DIG_MIN_U = 3'd3;
   localparam logic [2:0] DIG_SEC_T = 3'd4;
   localparam logic [2:0] DIG_SEC_U = 3'd5;

   localparam logic [5:0] HR_MAX = 6'd23;
   localparam logic [5:0] MS_MAX = 6'd59;

   // Out-of-range fields override the digit with a dash.
   function automatic logic [6:0] digit_code(input logic oor, input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = SEG_0;
         4'd1:    c = SEG_1;
         4'd2:    c = SEG_2;
         4'd3:    c = SEG_3;
         4'd4:    c = SEG_4;
         4'd5:    c = SEG_5;
         4'd6:    c = SEG_6;
         4'd7:    c = SEG_7;
         4'd8:    c = SEG_8;
         4'd9:    c = SEG_9;
         default: c = SEG_DASH;
      endcase
      return oor ? SEG_DASH : c;
   endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational 0..63 to two BCD digits, with a flag for values above MAX.
module bin2bcd_2digit #(
   parameter logic [5:0] MAX = 6'd59
) (
   input  logic [5:0] val_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       oor_o
);

   always_comb begin
      tens_o = 4'd0;
      for (int t = 1; t <= 6; t++) begin
         if (val_i >= 6'(t * 10)) tens_o = 4'(t);
      end
      units_o = 4'(val_i - ({2'b00, tens_o} * 6'd10));
      oor_o   = (val_i > MAX);
   end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH.MM.SS scanner: per-frame snapshot of the time,
// one dead cycle at the start of every slot, fully registered pin outputs.
module clock_display_scan
   import clock_display_pkg::*;
#(
   parameter int DWELL          = 10,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] hr,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_start
);

   localparam int CW = $clog2(DWELL);
   localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [5:0] AN_OFF  = {6{SEG_ACTIVE_LOW}};

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    digit_q, digit_d;
   logic [4:0]    snap_hr_q;
   logic [5:0]    snap_min_q, snap_sec_q;
   logic [6:0]    seg_q, seg_d;
   logic [5:0]    an_q, an_d;
   logic          dp_q, dp_d;
   logic          fs_q;
   logic          snap_en, cnt_last, an_act;
   logic [6:0]    code;

   logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
   logic       hr_oor, min_oor, sec_oor;

   bin2bcd_2digit #(.MAX(HR_MAX)) u_hr (
      .val_i({1'b0, snap_hr_q}), .tens_o(hr_t), .units_o(hr_u), .oor_o(hr_oor));
   bin2bcd_2digit #(.MAX(MS_MAX)) u_min (
      .val_i(snap_min_q), .tens_o(min_t), .units_o(min_u), .oor_o(min_oor));
   bin2bcd_2digit #(.MAX(MS_MAX)) u_sec (
      .val_i(snap_sec_q), .tens_o(sec_t), .units_o(sec_u), .oor_o(sec_oor));

   always_comb begin
      cnt_last = (cnt_q == CW'(DWELL - 1));
      cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
      digit_d  = digit_q;
      if (cnt_last) digit_d = (digit_q == DIG_SEC_U) ? DIG_HR_T : digit_q + 3'd1;
      snap_en  = (digit_q == DIG_HR_T) && (cnt_q == '0);

      case (digit_q)
         DIG_HR_T:  code = digit_code(hr_oor, hr_t);
         DIG_HR_U:  code = digit_code(hr_oor, hr_u);
         DIG_MIN_T: code = digit_code(min_oor, min_t);
         DIG_MIN_U: code = digit_code(min_oor, min_u);
         DIG_SEC_T: code = digit_code(sec_oor, sec_t);
         DIG_SEC_U: code = digit_code(sec_oor, sec_u);
         default:   code = SEG_DASH;
      endcase

      // The first cycle of each slot is dead time to avoid ghosting.
      an_act = (cnt_q != '0) && !blank;
      an_d   = an_act ? (6'b1 << digit_q) : 6'b0;
      seg_d  = an_act ? code : 7'h00;
      dp_d   = an_act && ((digit_q == DIG_HR_U) || (digit_q == DIG_MIN_U));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         digit_q    <= DIG_HR_T;
         snap_hr_q  <= '0;
         snap_min_q <= '0;
         snap_sec_q <= '0;
         seg_q      <= SEG_OFF;
         an_q       <= AN_OFF;
         dp_q       <= SEG_ACTIVE_LOW;
         fs_q       <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         if (snap_en) begin
            snap_hr_q  <= hr;
            snap_min_q <= min;
            snap_sec_q <= sec;
         end
         seg_q <= seg_d ^ SEG_OFF;
         an_q  <= an_d ^ AN_OFF;
         dp_q  <= dp_d ^ SEG_ACTIVE_LOW;
         fs_q  <= snap_en;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: edge-count based reference model checked every
// cycle, plus directed literal expectations and randomized traffic.
module tb_clock_display_scan;

   localparam int DW  = 4;
   localparam bit SAL = 1'b0;
   localparam int FR  = 6 * DW;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] hr = '0;
   logic [5:0] min = '0;
   logic [5:0] sec = '0;
   logic       blank = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frame_start;

   int vecs = 0;
   int fails = 0;

   clock_display_scan #(.DWELL(DW), .SEG_ACTIVE_LOW(SAL)) dut (
      .clk(clk), .rst_n(rst_n), .hr(hr), .min(min), .sec(sec), .blank(blank),
      .seg(seg), .dp(dp), .an(an), .frame_start(frame_start));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: count rising edges since reset; edge e reflects scan position e-1.
   int         m_edges;
   logic [4:0] s_hr;
   logic [5:0] s_min, s_sec;
   logic       m_blank;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges <= 0;
         s_hr    <= '0;
         s_min   <= '0;
         s_sec   <= '0;
         m_blank <= 1'b0;
      end else begin
         if (m_edges % FR == 0) begin
            s_hr  <= hr;
            s_min <= min;
            s_sec <= sec;
         end
         m_edges <= m_edges + 1;
         m_blank <= blank;
      end
   end

   function automatic logic [6:0] enc(input int v, input int mx, input bit tens);
      int d;
      if (v > mx) return 7'h40;
      d = tens ? v / 10 : v % 10;
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   int         p, slot, c, fv, fmx;
   bit         act;
   logic [6:0] e_seg;
   logic [5:0] e_an;
   logic       e_dp, e_fs;

   always @(negedge clk) begin
      e_seg = '0; e_an = '0; e_dp = 1'b0; e_fs = 1'b0;
      if (rst_n && m_edges > 0) begin
         p    = m_edges - 1;
         slot = (p / DW) % 6;
         c    = p % DW;
         act  = (c != 0) && !m_blank;
         fv   = (slot / 2 == 0) ? int'(s_hr) : (slot / 2 == 1) ? int'(s_min) : int'(s_sec);
         fmx  = (slot / 2 == 0) ? 23 : 59;
         if (act) begin
            e_an  = 6'(1 << slot);
            e_seg = enc(fv, fmx, (slot % 2) == 0);
            e_dp  = (slot == 1) || (slot == 3);
         end
         e_fs = (p % FR) == 0;
      end
      chk("an",          an,          e_an ^ {6{SAL}});
      chk("seg",         seg,         e_seg ^ {7{SAL}});
      chk("dp",          dp,          e_dp ^ SAL);
      chk("frame_start", frame_start, e_fs);
      chk("an_onehot",   ($countones(an ^ {6{SAL}}) <= 1), 1);
   end

   task automatic at_edge(input int tgt);
      int guard = 0;
      while (m_edges < tgt && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (m_edges != tgt) begin
         vecs++; fails++;
         $display("FAIL at_edge: reached edge %0d, wanted %0d", m_edges, tgt);
      end
   endtask

   logic [6:0] lit_a [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
   logic [6:0] lit_b [6] = '{7'h40, 7'h40, 7'h3F, 7'h6D, 7'h40, 7'h40};

   initial begin
      hr = 5'd12; min = 6'd34; sec = 6'd56;
      repeat (3) @(negedge clk);
      chk("rst_an", an, 6'h00);
      chk("rst_fs", frame_start, 0);
      rst_n = 1'b1;

      // Basic frame 12:34:56
      at_edge(1);  chk("lit_fs_first", frame_start, 1);
      for (int s = 0; s < 6; s++) begin
         at_edge(s * DW + 2);
         chk("lit_seg_a", seg, lit_a[s]);
         chk("lit_dp_a", dp, (s == 1 || s == 3));
      end
      at_edge(25); chk("lit_fs_period", frame_start, 1);
      at_edge(26); chk("lit_fs_low", frame_start, 0);

      // Snapshot hold: sec changes during slot 2
      at_edge(35); sec = 6'd57;
      at_edge(46); chk("lit_hold_old", seg, 7'h7D);
      at_edge(66); chk("lit_hold_t", seg, 7'h6D);
      at_edge(70); chk("lit_hold_new", seg, 7'h07);

      // Out of range fields
      at_edge(71); hr = 5'd24; min = 6'd5; sec = 6'd60;
      for (int s = 0; s < 6; s++) begin
         at_edge(74 + 4 * s);
         chk("lit_seg_oor", seg, lit_b[s]);
      end

      // Blanking for two frames
      at_edge(95); blank = 1'b1;
      at_edge(110); chk("lit_blank_an", an, 6'h00);
      at_edge(121); chk("lit_blank_fs", frame_start, 1);
      at_edge(143); blank = 1'b0;

      // Asynchronous reset during slot 3
      at_edge(158);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("lit_async_an", an, 6'h00);
      chk("lit_async_seg", seg, 7'h00);
      chk("lit_async_dp", dp, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      at_edge(1); chk("lit_restart_fs", frame_start, 1);
      at_edge(6); chk("lit_restart_an", an, 6'b000010);

      // Randomized traffic
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if ($urandom_range(7) == 0) begin
            hr  = 5'($urandom_range(31));
            min = 6'($urandom_range(63));
            sec = 6'($urandom_range(63));
         end
         if ($urandom_range(39) == 0) blank = ~blank;
         if ($urandom_range(299) == 0) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter DWELL, default 10, meaning clock cycles per digit slot; legal range 2..255.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1, meaning when 1 the seg, dp and an outputs are inverted at the pins.
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 hr  input  5  binary hours; legal range 0..23.
REQ-006 min  input  6  binary minutes; legal range 0..59.
REQ-007 sec  input  6  binary seconds; legal range 0..59.
REQ-008 blank  input  1  when 1, all anodes are forced inactive.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-010 dp  output  1  decimal point, registered.
REQ-011 an  output  6  digit enables, one-hot, registered; an[0] is hours tens and an[5] is seconds units.
REQ-012 frame_start  output  1  one-cycle pulse marking a snapshot capture.

Function
REQ-013 A dwell counter SHALL count 0..DWELL-1; at DWELL-1 the digit index (0..5) SHALL advance, and SHALL wrap from 5 to 0.
REQ-014 Digit order SHALL be: 0 = hr tens, 1 = hr units, 2 = min tens, 3 = min units, 4 = sec tens, 5 = sec units.
REQ-015 Snapshot: when digit = 0 and count = 0, hr, min and sec SHALL be captured; frame_start SHALL be high in the following cycle only.
REQ-016 The whole frame (6*DWELL cycles) SHALL display only the snapshot, so input changes mid-frame have no effect until the next frame.
REQ-017 Dead time: in the first cycle of every slot, an SHALL be all-inactive; in the remaining DWELL-1 cycles, an SHALL be one-hot on the current digit.
REQ-018 Outputs SHALL lag the internal digit/count state by exactly one cycle, because they are registered.
REQ-019 Encoding (active-high, hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, DASH=40.
REQ-020 Each field SHALL be split into tens and units digits by binary-to-BCD conversion.
REQ-021 The hr tens digit SHALL show a leading zero (00..23 are all displayed as two digits).
REQ-022 Out-of-range fields SHALL show DASH on both of that field's digits: hr > 23, min > 59, sec > 59.
REQ-023 dp SHALL be active only while digit 1 or digit 3 is enabled, acting as the HH.MM.SS separators.
REQ-024 blank = 1 SHALL force an all-inactive and dp inactive; scanning, snapshots and frame_start SHALL continue unchanged.
REQ-025 When an is all-inactive, seg SHALL be all-off.
REQ-026 With SEG_ACTIVE_LOW = 1, seg, dp and an SHALL be bitwise inverted after all of the above logic.

Reset
REQ-027 While rst_n = 0: digit = 0, count = 0, snapshot = 00:00:00, an, seg and dp inactive at pin polarity, frame_start = 0.
REQ-028 Assertion of rst_n SHALL take effect immediately, independent of clk, including in the middle of a frame.
REQ-029 The first rising edge after rst_n deasserts SHALL take a snapshot, and frame_start SHALL pulse in the next cycle.

Structure
REQ-030 A shared package clock_display_pkg SHALL hold the segment code constants (SEG_0..SEG_9, SEG_DASH), the digit index constants and the field maxima (23, 59).
REQ-031 The block SHALL use one combinational sub-module, bin2bcd_2digit, which converts 0..63 to tens and units with an out-of-range flag, instantiated once per field.
REQ-032 Target size is 150-250 lines of RTL in total.

Verification (DWELL=4, SEG_ACTIVE_LOW=0)
REQ-033 Basic frame: reset, then hr=12, min=34, sec=56 -> the active cycles of slots 0..5 show seg 06, 5B, 4F, 66, 6D, 7D; dp = 1 only in slots 1 and 3; frame_start pulses every 24 cycles.
REQ-034 Snapshot hold: starting from 12:34:56, change sec to 57 during slot 2 -> the current frame still shows 5/6 (6D, 7D); the next frame shows 5/7 (6D, 07).
REQ-035 Out of range: hr=24, min=05, sec=60 -> slots 0, 1, 4, 5 show 40; slots 2 and 3 show 3F and 6D.
REQ-036 Blanking: blank=1 for two frames -> an = 000000, seg = 00 and dp = 0 throughout, while frame_start still pulses every 24 cycles.
REQ-037 Reset mid-frame: drive rst_n low between clock edges during slot 3 -> outputs go inactive at once; after release, scanning restarts at slot 0 with a frame_start pulse.
REQ-038 Dead time (checker over 1000 cycles): an = 0 in the first cycle of every slot, one-hot in all other cycles, and never two anodes active at once.
